// File: rtl/latch_xing_arbiter_if.sv
// Requester, crossing-register and status bundle for latch_xing_arbiter.
interface latch_xing_arbiter_if #(
   parameter int unsigned width = 32,
   parameter int unsigned nreq  = 4
);
   localparam int unsigned id_w = $clog2(nreq);

   logic [nreq-1:0]       REQ;
   logic [nreq*width-1:0] REQ_DATA;
   logic [nreq-1:0]       GNT;
   logic                  XEN;
   logic [width-1:0]      XD;
   logic                  XTAG;
   logic                  DACK_TOG;
   logic                  ERR_CLR;
   logic                  BUSY;
   logic [id_w-1:0]       CUR_ID;
   logic                  TIMEOUT_ERR;

   // Requesters and destination side
   modport master (
      output REQ, REQ_DATA, DACK_TOG, ERR_CLR,
      input  GNT, XEN, XD, XTAG, BUSY, CUR_ID, TIMEOUT_ERR
   );

   // Arbiter side
   modport slave (
      input  REQ, REQ_DATA, DACK_TOG, ERR_CLR,
      output GNT, XEN, XD, XTAG, BUSY, CUR_ID, TIMEOUT_ERR
   );
endinterface

// File: rtl/latch_xing_arbiter.sv
// Round-robin arbiter sharing one flop-plus-latch crossing register among
// nreq requesters; holds each load, then waits for the toggle ack echoed
// from the destination domain, with a timeout for a dead destination.
module latch_xing_arbiter #(
   parameter int unsigned width       = 32,
   parameter int unsigned nreq        = 4,
   parameter int unsigned sync_stages = 2,
   parameter int unsigned hold_cycles = 4,
   parameter int unsigned timeout     = 255
) (
   input  logic SCLK,
   input  logic SRST,
   latch_xing_arbiter_if.slave bus
);
   localparam int unsigned id_w   = $clog2(nreq);
   localparam int unsigned hold_w = $clog2(hold_cycles + 1);
   localparam int unsigned to_w   = $clog2(timeout + 1);

   typedef enum logic [1:0] {IDLE, HOLD, WAIT_ACK} state_t;

   state_t               state_q, state_d;
   logic                 tag_q, tag_d;
   logic [id_w-1:0]      ptr_q, ptr_d;
   logic [id_w-1:0]      cur_id_q, cur_id_d;
   logic [hold_w-1:0]    hold_q, hold_d;
   logic [to_w-1:0]      to_q, to_d;
   logic                 err_q, err_d;
   logic                 busy_q;
   logic [sync_stages-1:0] sync_q;
   logic                 ack_sync;

   logic [width-1:0]     lane [nreq];
   logic                 any_req;
   logic [id_w-1:0]      win;
   int unsigned          idx;
   logic                 load_c;
   logic [nreq-1:0]      gnt_c;
   logic [width-1:0]     xd_c;

   // Ack toggle synchronizer into SCLK
   always_ff @(posedge SCLK) begin
      if (SRST) sync_q <= '0;
      else      sync_q <= {sync_q[sync_stages-2:0], bus.DACK_TOG};
   end
   assign ack_sync = sync_q[sync_stages-1];

   // Split the flat payload bus into per-requester lanes
   always_comb begin
      for (int i = 0; i < int'(nreq); i++) lane[i] = bus.REQ_DATA[i*int'(width) +: width];
   end

   // Round-robin search starting at the pointer, wrapping around
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      idx     = 0;
      for (int unsigned i = 0; i < nreq; i++) begin
         idx = (32'(ptr_q) + i) % nreq;
         if (!any_req && bus.REQ[id_w'(idx)]) begin
            any_req = 1'b1;
            win     = id_w'(idx);
         end
      end
   end

   // Next-state and load outputs; a load is suppressed while SRST is high
   always_comb begin
      state_d  = state_q;
      tag_d    = tag_q;
      ptr_d    = ptr_q;
      cur_id_d = cur_id_q;
      hold_d   = hold_q;
      to_d     = to_q;
      err_d    = err_q;
      load_c   = 1'b0;
      gnt_c    = '0;
      xd_c     = '0;

      if (bus.ERR_CLR) err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (any_req && !SRST) begin
               load_c     = 1'b1;
               gnt_c[win] = 1'b1;
               xd_c       = lane[win];
               tag_d      = ~tag_q;
               cur_id_d   = win;
               ptr_d      = (win == id_w'(nreq - 1)) ? '0 : win + id_w'(1);
               hold_d     = '0;
               state_d    = HOLD;
            end
         end
         HOLD: begin
            if (hold_q == hold_w'(hold_cycles - 1)) begin
               to_d    = '0;
               state_d = WAIT_ACK;
            end else begin
               hold_d = hold_q + hold_w'(1);
            end
         end
         WAIT_ACK: begin
            if (ack_sync == tag_q) begin
               state_d = IDLE;
            end else if (to_q == to_w'(timeout - 1)) begin
               err_d   = 1'b1;
               tag_d   = ack_sync;
               state_d = IDLE;
            end else begin
               to_d = to_q + to_w'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and status registers
   always_ff @(posedge SCLK) begin
      if (SRST) begin
         state_q  <= IDLE;
         tag_q    <= 1'b0;
         ptr_q    <= '0;
         cur_id_q <= '0;
         hold_q   <= '0;
         to_q     <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tag_q    <= tag_d;
         ptr_q    <= ptr_d;
         cur_id_q <= cur_id_d;
         hold_q   <= hold_d;
         to_q     <= to_d;
         err_q    <= err_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   assign bus.GNT         = gnt_c;
   assign bus.XEN         = load_c;
   assign bus.XD          = xd_c;
   assign bus.XTAG        = tag_q ^ load_c;
   assign bus.BUSY        = busy_q;
   assign bus.CUR_ID      = cur_id_q;
   assign bus.TIMEOUT_ERR = err_q;
endmodule

// File: doc/latch_xing_arbiter.md
Name: latch_xing_arbiter

Overview:
- SCLK-domain controller that shares one flop-plus-latch clock-crossing register among nreq requesters.
- Arbitrates round-robin and drives the crossing register's enable and data.
- Holds the loaded value stable for a minimum number of cycles, then waits for a toggle acknowledge returned from the destination domain before allowing the next load. A timeout guards against a dead destination.

Parameters:
width, 32, payload bits per requester.
nreq, 4, number of requesters (2..16).
sync_stages, 2, flops in the DACK_TOG synchronizer (>=2).
hold_cycles, 4, SCLK cycles the loaded value is held after a load before ack is examined (>=1).
timeout, 255, maximum SCLK cycles spent in WAIT_ACK before the error exit (>=1).

Ports:
SCLK  in  1  clock; all logic is posedge SCLK.
SRST  in  1  reset, synchronous, active-high.
REQ  in  nreq  per-requester request level.
REQ_DATA  in  nreq*width  payloads; requester i occupies bits [i*width +: width].
GNT  out  nreq  one-hot, one-cycle grant; the payload is consumed in that cycle.
XEN  out  1  enable to the crossing register source flop.
XD  out  width  data to the crossing register.
XTAG  out  1  tag bit loaded alongside XD; the destination echoes it on DACK_TOG.
DACK_TOG  in  1  asynchronous ack toggle from the destination domain.
ERR_CLR  in  1  clears TIMEOUT_ERR.
BUSY  out  1  high when state != IDLE.
CUR_ID  out  clog2(nreq)  index of the last granted requester.
TIMEOUT_ERR  out  1  sticky timeout flag.

Behaviour:
- Reset (SRST=1 at a posedge): state=IDLE, tag_q=0, ack synchronizer=0, RR pointer selects req0 as highest priority, hold/timeout counters=0, CUR_ID=0, TIMEOUT_ERR=0.
  - Combinational outputs are 0 while in IDLE with no REQ.
  - SRST mid-operation aborts immediately with no GNT. The destination side must be reset together with this block.
- ack_sync is DACK_TOG passed through sync_stages flops.
- FSM states: IDLE, HOLD, WAIT_ACK.
- IDLE:
  - If any REQ is set, the round-robin winner w is chosen combinationally in the same cycle (zero latency).
  - GNT[w]=1, XEN=1, XD=REQ_DATA[w], XTAG=~tag_q.
  - At the clock edge: tag_q<=~tag_q, CUR_ID<=w, pointer<=w+1 mod nreq, hold counter<=0, state<=HOLD.
  - When not loading, XEN=0, GNT=0, XD=0, and XTAG=tag_q (XTAG = tag_q XOR XEN).
- Round-robin rule: search starts at the pointer and wraps; the pointer advances only on a grant.
- HOLD:
  - Lasts exactly hold_cycles cycles; ack_sync is ignored.
  - Then: state<=WAIT_ACK and timeout counter<=0.
- WAIT_ACK:
  - If ack_sync==tag_q: state<=IDLE; a new grant is possible the following cycle.
  - Else the counter increments. When it has counted timeout cycles without a match: TIMEOUT_ERR<=1, tag_q<=ack_sync (realign), state<=IDLE.
  - Ack match and timeout in the same cycle: ack wins, no error.
- An ack that arrives early (during HOLD) is accepted on the first WAIT_ACK cycle.
- Minimum load-to-load spacing is hold_cycles + 2 cycles.
- TIMEOUT_ERR: set and ERR_CLR in the same cycle resolves to set; otherwise ERR_CLR=1 clears it.
- REQ deasserted without a grant is legal. Requesters must hold REQ and REQ_DATA until GNT.
- BUSY is registered from state; it is high from the cycle after the load through the last WAIT_ACK cycle.
- Counter widths: clog2(hold_cycles+1) and clog2(timeout+1); no wrap is permitted.

Test Plan (width=8, nreq=4, sync_stages=2, hold_cycles=4, timeout=16):
1. Single load: REQ=0010, REQ_DATA[1]=0xA5 at cycle 0; DACK_TOG toggled to 1 at cycle 0.
   -> Cycle 0: GNT=0010, XEN=1, XD=0xA5, XTAG=1.
   -> HOLD cycles 1-4, WAIT_ACK at cycle 5 matches, IDLE at cycle 6; BUSY=1 in cycles 1-5; CUR_ID=1.
2. Fairness: REQ=1111 held, bench echoes XTAG on DACK_TOG 3 cycles after each XEN.
   -> Grant order 0,1,2,3,0, one XEN per load, no grant while BUSY=1.
3. Skip and wrap: after a grant to req2, REQ=0011.
   -> Next grant goes to req0 (wrap), then req1.
4. Timeout: single load, DACK_TOG held at 0.
   -> After 16 WAIT_ACK cycles: TIMEOUT_ERR=1, tag_q=0, IDLE.
   -> Next load drives XTAG=1. ERR_CLR=1 clears the flag; ERR_CLR coincident with a new timeout leaves it 1.
5. Ack on the final timeout cycle: ack_sync matches on WAIT_ACK cycle 16.
   -> IDLE with TIMEOUT_ERR=0.
6. Reset mid-op: SRST=1 during WAIT_ACK with REQ=1000 held.
   -> Next cycle BUSY=0 and CUR_ID=0. The first grant after SRST=0 goes to req3 with XTAG=1, and req0 takes priority on a tie.
